imem_arb: RTL and testbench
===========================

# imem_arb

Two-port arbiter that shares the single-port, synchronous-read instruction RAM between the core fetch stage and the program-load/debug port. It sits between the fetch stage, the loader, and the instruction RAM. It gives fetch fixed priority, bounds loader starvation with a wait counter, and supports a load mode that locks fetch out while a program image is written. It also returns read data to the correct requester one cycle after grant.

## Interface
- n, 32, data and byte-address width of both requester ports
- AW, 5, RAM word-address width (32 words)
- MAXWAIT, 4, maximum consecutive cycles a requesting loader can be denied; range 1..15
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- load_mode  in  1  1 = fetch is never granted; loader owns the RAM
- f_req  in  1  fetch read request
- f_addr  in  n  fetch byte address
- f_gnt  out  1  fetch request accepted this cycle
- f_rvalid  out  1  f_rdata valid this cycle
- f_rdata  out  n  fetched instruction
- l_req  in  1  loader request
- l_we  in  1  1 = write, 0 = read
- l_addr  in  n  loader byte address
- l_wdata  in  n  loader write data
- l_gnt  out  1  loader request accepted this cycle
- l_rvalid  out  1  l_rdata valid this cycle (reads only)
- l_rdata  out  n  loader read data
- m_addr  out  AW  RAM word address
- m_we  out  1  RAM write enable
- m_wdata  out  n  RAM write data
- m_rdata  in  n  RAM read data, valid the cycle after the address is presented

## Operation
- Word index is addr[AW+1:2]. Bits [1:0] and bits above AW+1 are ignored, so out-of-range addresses wrap modulo 2^AW words.
- Grant decision is combinational, with at most one grant per cycle:
  - The loader wins if load_mode=1, if f_req=0, or if wait_cnt >= MAXWAIT.
  - Otherwise fetch wins when f_req=1.
  - In load_mode, f_gnt is always 0.
- m_addr, m_we and m_wdata follow the granted port. m_we = l_gnt & l_we. With no grant, m_addr holds the f_addr index and m_we=0.
- wait_cnt (4 bits):
  - Increments when l_req=1 and l_gnt=0, saturating at 15.
  - Clears when l_gnt=1 or l_req=0.
- Read owner register rd_own ∈ {OWN_NONE, OWN_FETCH, OWN_LOAD} is set from this cycle's read grant:
  - fetch grant → OWN_FETCH
  - loader grant with l_we=0 → OWN_LOAD
  - otherwise OWN_NONE
- f_rvalid = (rd_own==OWN_FETCH) and l_rvalid = (rd_own==OWN_LOAD).
- f_rdata and l_rdata equal m_rdata when their rvalid is 1, and 0 otherwise.
- Loader writes produce no rvalid. A read of the same word in any later cycle returns the new data.

## Timing
- Grant is in the same cycle as the request. Read latency is 1 cycle from grant to rvalid. Throughput is 1 access per cycle total.
- Requesters hold req and addr until they see gnt. A request not granted is not queued inside the block.
- Reset values: rd_own=OWN_NONE, wait_cnt=0, f_rvalid=l_rvalid=0, f_rdata=l_rdata=0. While reset=1, f_gnt=l_gnt=0 and m_we=0.
- Reset mid-operation: a read granted in the cycle reset asserts never produces rvalid.
- Simultaneous f_req and l_req with wait_cnt<MAXWAIT and load_mode=0: fetch is granted.
  - With MAXWAIT=4 and continuous fetch, the loader is granted on its 5th request cycle.
  - Fetch is granted in the cycle after that.
- A load_mode change takes effect in the same cycle. It does not cancel an outstanding rvalid.

## Structure
- Shared package imem_pkg holds:
  - the AW and MAXWAIT default localparams
  - the typedef enum logic [1:0] rd_own_t {OWN_NONE, OWN_FETCH, OWN_LOAD}
  - the function word_idx(addr), which returns addr[AW+1:2]
- One sub-module, imem_wait_ctr: the saturating 4-bit starvation counter with inputs clk, reset, inc, clr and output cnt.
- Top level contains the combinational grant/mux logic and the rd_own register.

## Test plan
- Reset then fetch stream: f_req=1, f_addr=0x0,0x4,0x8 → f_gnt=1 each cycle. f_rvalid=1 one cycle later with RAM words 0,1,2. l_rvalid=0 throughout.
- Load mode write then readback: load_mode=1, loader writes 0xDEADBEEF to 0x10, then reads 0x10 → m_we=1 with m_addr=4 on the write. l_rvalid=1 with 0xDEADBEEF one cycle after the read grant. f_gnt=0 even with f_req=1.
- Starvation bound: f_req held 1, l_req=1 read from 0x8, MAXWAIT=4 → l_gnt=0 for 4 cycles and 1 on the 5th. wait_cnt returns to 0 and fetch regains the grant the next cycle.
- Wrap-around: loader reads 0x80 and 0x83 → m_addr=0 for both, returning word 0.
- Async reset mid-read: fetch granted at 0x4, reset pulses before the next edge → f_rvalid stays 0. All outputs reach their reset values without a clock edge.
- Idle: f_req=l_req=0 for 10 cycles → no grants, m_we=0, both rvalids 0, wait_cnt=0.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: definitions shared by the instruction-RAM arbiter and its testbench.
//   IMEM_W       - data / byte-address width of the requester ports
//   IMEM_AW      - RAM word-address width
//   IMEM_MAXWAIT - default starvation bound for the loader
//   rd_own_t     - which requester owns the read data returning next cycle
//   word_idx()   - byte address to RAM word index (wraps modulo 2^IMEM_AW words)
package imem_pkg;

   localparam int unsigned IMEM_W       = 32;
   localparam int unsigned IMEM_AW      = 5;
   localparam int unsigned IMEM_MAXWAIT = 4;

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_LOAD  = 2'd2
   } rd_own_t;

   // Byte offset bits and everything above the RAM depth are dropped,
   // so large addresses alias back onto the 2^IMEM_AW words.
   function automatic logic [IMEM_AW-1:0] word_idx(input logic [IMEM_W-1:0] addr);
      return addr[IMEM_AW+1:2];
   endfunction

endpackage

// File: rtl/imem_wait_ctr.sv
// imem_wait_ctr: 4-bit saturating starvation counter.
//   clk   - clock
//   reset - asynchronous active-high reset, clears the count
//   inc   - loader requested and was denied this cycle
//   clr   - loader was granted or is not requesting (wins over inc)
//   cnt   - current count, saturates at 15
module imem_wait_ctr (
   input  logic       clk,
   input  logic       reset,
   input  logic       inc,
   input  logic       clr,
   output logic [3:0] cnt
);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = 4'd0;
      end else if (inc && (cnt_q != 4'hF)) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/imem_arb.sv
// imem_arb: shares a single-port, synchronous-read instruction RAM between the
// fetch stage (fixed priority) and the program-load/debug port.
//   clk, reset                       - clock, asynchronous active-high reset
//   load_mode                        - 1: loader owns the RAM, fetch never granted
//   f_req/f_addr -> f_gnt            - fetch read request, same-cycle grant
//   f_rvalid/f_rdata                 - fetch read data, one cycle after grant
//   l_req/l_we/l_addr/l_wdata -> l_gnt - loader read/write request, same-cycle grant
//   l_rvalid/l_rdata                 - loader read data, one cycle after read grant
//   m_addr/m_we/m_wdata, m_rdata     - RAM port (read data valid one cycle later)
module imem_arb
   import imem_pkg::*;
#(
   parameter int unsigned n       = IMEM_W,
   parameter int unsigned AW      = IMEM_AW,
   parameter int unsigned MAXWAIT = IMEM_MAXWAIT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_mode,
   input  logic          f_req,
   input  logic [n-1:0]  f_addr,
   output logic          f_gnt,
   output logic          f_rvalid,
   output logic [n-1:0]  f_rdata,
   input  logic          l_req,
   input  logic          l_we,
   input  logic [n-1:0]  l_addr,
   input  logic [n-1:0]  l_wdata,
   output logic          l_gnt,
   output logic          l_rvalid,
   output logic [n-1:0]  l_rdata,
   output logic [AW-1:0] m_addr,
   output logic          m_we,
   output logic [n-1:0]  m_wdata,
   input  logic [n-1:0]  m_rdata
);

   localparam logic [3:0] MAXW = 4'(MAXWAIT);

   logic       l_win;
   logic [3:0] wait_cnt;
   rd_own_t    rd_own_q;
   rd_own_t    rd_own_d;

   // Loader takes the RAM when it owns it outright, when fetch is idle, or
   // when it has been starved long enough. Grants are gated off during reset
   // so nothing reaches the RAM while the block is being reset.
   assign l_win = l_req && (load_mode || !f_req || (wait_cnt >= MAXW));
   assign l_gnt = l_win && !reset;
   assign f_gnt = f_req && !load_mode && !l_win && !reset;

   // Idle cycles still present the fetch index so the RAM address is stable.
   assign m_addr  = l_gnt ? word_idx(l_addr) : word_idx(f_addr);
   assign m_we    = l_gnt && l_we;
   assign m_wdata = l_gnt ? l_wdata : '0;

   imem_wait_ctr u_wait_ctr (
      .clk   (clk),
      .reset (reset),
      .inc   (l_req && !l_gnt),
      .clr   (l_gnt || !l_req),
      .cnt   (wait_cnt)
   );

   // Remember who issued this cycle's read so the returning data is steered.
   always_comb begin
      rd_own_d = OWN_NONE;
      if (f_gnt) begin
         rd_own_d = OWN_FETCH;
      end else if (l_gnt && !l_we) begin
         rd_own_d = OWN_LOAD;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_own_q <= OWN_NONE;
      end else begin
         rd_own_q <= rd_own_d;
      end
   end

   assign f_rvalid = (rd_own_q == OWN_FETCH) && !reset;
   assign l_rvalid = (rd_own_q == OWN_LOAD) && !reset;
   assign f_rdata  = f_rvalid ? m_rdata : '0;
   assign l_rdata  = l_rvalid ? m_rdata : '0;

endmodule

// File: tb/tb_imem_arb.sv
module tb_imem_arb;
   import imem_pkg::*;

   localparam int MAXW  = 4;
   localparam int DEPTH = 32;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load_mode = 1'b0;
   logic        f_req = 1'b0;
   logic [31:0] f_addr = '0;
   logic        f_gnt;
   logic        f_rvalid;
   logic [31:0] f_rdata;
   logic        l_req = 1'b0;
   logic        l_we = 1'b0;
   logic [31:0] l_addr = '0;
   logic [31:0] l_wdata = '0;
   logic        l_gnt;
   logic        l_rvalid;
   logic [31:0] l_rdata;
   logic [4:0]  m_addr;
   logic        m_we;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;

   always #5 clk = ~clk;

   imem_arb dut (
      .clk       (clk),
      .reset     (reset),
      .load_mode (load_mode),
      .f_req     (f_req),
      .f_addr    (f_addr),
      .f_gnt     (f_gnt),
      .f_rvalid  (f_rvalid),
      .f_rdata   (f_rdata),
      .l_req     (l_req),
      .l_we      (l_we),
      .l_addr    (l_addr),
      .l_wdata   (l_wdata),
      .l_gnt     (l_gnt),
      .l_rvalid  (l_rvalid),
      .l_rdata   (l_rdata),
      .m_addr    (m_addr),
      .m_we      (m_we),
      .m_wdata   (m_wdata),
      .m_rdata   (m_rdata)
   );

   // Instruction RAM attached to the arbiter: synchronous read, read-first.
   logic [31:0] ram [DEPTH];
   always @(posedge clk) begin
      if (m_we) ram[m_addr] <= m_wdata;
      m_rdata <= ram[m_addr];
   end

   // Reference model state: expected memory image, how many cycles in a row
   // the loader has been refused, and the read expected to return next cycle.
   logic [31:0] shadow [DEPTH];
   int          denied;
   int          pend_kind;   // 0 none, 1 fetch, 2 loader
   logic [31:0] pend_data;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        lm;
      logic        fr;
      logic [31:0] fa;
      logic        lr;
      logic        lwe;
      logic [31:0] la;
      logic [31:0] lwd;
      logic        e_fg;
      logic        e_lg;
      logic [4:0]  e_ma;
      logic        e_mwe;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int idx_of(input logic [31:0] a);
      return int'((a / 4) % DEPTH);
   endfunction

   // Applies one cycle of stimulus (caller is just after a rising edge),
   // checks every output against the model, then advances the model.
   task automatic step(input vec_t v, input bit use_tab);
      bit fg, lg;
      int ma;
      load_mode = v.lm; f_req = v.fr; f_addr = v.fa;
      l_req = v.lr; l_we = v.lwe; l_addr = v.la; l_wdata = v.lwd;
      #2;
      lg = v.lr && (v.lm || !v.fr || denied >= MAXW);
      fg = v.fr && !v.lm && !lg;
      ma = lg ? idx_of(v.la) : idx_of(v.fa);
      chk("f_gnt", 32'(f_gnt), 32'(fg));
      chk("l_gnt", 32'(l_gnt), 32'(lg));
      chk("m_addr", 32'(m_addr), 32'(ma));
      chk("m_we", 32'(m_we), 32'(lg && v.lwe));
      if (lg && v.lwe) chk("m_wdata", m_wdata, v.lwd);
      chk("f_rvalid", 32'(f_rvalid), 32'(pend_kind == 1));
      chk("l_rvalid", 32'(l_rvalid), 32'(pend_kind == 2));
      chk("f_rdata", f_rdata, (pend_kind == 1) ? pend_data : 32'h0);
      chk("l_rdata", l_rdata, (pend_kind == 2) ? pend_data : 32'h0);
      if (use_tab) begin
         chk("tab_f_gnt", 32'(f_gnt), 32'(v.e_fg));
         chk("tab_l_gnt", 32'(l_gnt), 32'(v.e_lg));
         chk("tab_m_addr", 32'(m_addr), 32'(v.e_ma));
         chk("tab_m_we", 32'(m_we), 32'(v.e_mwe));
      end
      $display("txn lm=%0b f=%0b/%h l=%0b we=%0b/%h gnt f=%0b l=%0b m_addr=%0d rv f=%0b l=%0b",
               v.lm, v.fr, v.fa, v.lr, v.lwe, v.la, f_gnt, l_gnt, m_addr, f_rvalid, l_rvalid);
      @(posedge clk);
      #1;
      denied = (v.lr && !lg) ? ((denied < 15) ? denied + 1 : 15) : 0;
      pend_kind = 0;
      pend_data = '0;
      if (fg) begin
         pend_kind = 1; pend_data = shadow[ma];
      end else if (lg && !v.lwe) begin
         pend_kind = 2; pend_data = shadow[ma];
      end
      if (lg && v.lwe) shadow[ma] = v.lwd;
   endtask

   function automatic vec_t mk(input logic lm, input logic fr, input logic [31:0] fa,
                               input logic lr, input logic lwe, input logic [31:0] la,
                               input logic [31:0] lwd, input logic efg, input logic elg,
                               input logic [4:0] ema, input logic emwe);
      vec_t v;
      v.lm = lm; v.fr = fr; v.fa = fa; v.lr = lr; v.lwe = lwe; v.la = la; v.lwd = lwd;
      v.e_fg = efg; v.e_lg = elg; v.e_ma = ema; v.e_mwe = emwe;
      return v;
   endfunction

   vec_t tab [$];
   vec_t z;

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         ram[i]    = 32'hA000_0000 + 32'(i * 32'h0101);
         shadow[i] = 32'hA000_0000 + 32'(i * 32'h0101);
      end
      denied = 0; pend_kind = 0; pend_data = '0;
      z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Reset state.
      #2;
      chk("rst_f_gnt", 32'(f_gnt), 0);
      chk("rst_l_gnt", 32'(l_gnt), 0);
      chk("rst_m_we", 32'(m_we), 0);
      chk("rst_f_rvalid", 32'(f_rvalid), 0);
      chk("rst_l_rvalid", 32'(l_rvalid), 0);
      chk("rst_f_rdata", f_rdata, 0);
      chk("rst_l_rdata", l_rdata, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      //          lm fr fa     lr we la     wdata          fg lg ma mwe
      tab.push_back(mk(0, 1, 32'h0, 0, 0, 32'h0, 32'h0,         1, 0, 0, 0));
      tab.push_back(mk(0, 1, 32'h4, 0, 0, 32'h0, 32'h0,         1, 0, 1, 0));
      tab.push_back(mk(0, 1, 32'h8, 0, 0, 32'h0, 32'h0,         1, 0, 2, 0));
      tab.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0, 32'h0,         0, 0, 0, 0));
      tab.push_back(mk(1, 1, 32'hC, 1, 1, 32'h10, 32'hDEADBEEF, 0, 1, 4, 1));
      tab.push_back(mk(1, 1, 32'hC, 1, 0, 32'h10, 32'h0,        0, 1, 4, 0));
      tab.push_back(mk(1, 1, 32'hC, 0, 0, 32'h0, 32'h0,         0, 0, 3, 0));
      for (int i = 0; i < 4; i++)
         tab.push_back(mk(0, 1, 32'h20, 1, 0, 32'h8, 32'h0,     1, 0, 8, 0));
      tab.push_back(mk(0, 1, 32'h20, 1, 0, 32'h8, 32'h0,        0, 1, 2, 0));
      tab.push_back(mk(0, 1, 32'h24, 1, 0, 32'h8, 32'h0,        1, 0, 9, 0));
      tab.push_back(mk(0, 0, 32'h0, 1, 0, 32'h80, 32'h0,        0, 1, 0, 0));
      tab.push_back(mk(0, 0, 32'h0, 1, 0, 32'h83, 32'h0,        0, 1, 0, 0));
      tab.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0, 32'h0,         0, 0, 0, 0));
      foreach (tab[i]) step(tab[i], 1'b1);

      // Readback of the loader write lands one cycle after the read grant.
      step(mk(1, 0, 0, 1, 0, 32'h10, 0, 0, 1, 4, 0), 1'b1);
      chk("readback_l_rdata", l_rdata, 32'hDEADBEEF);
      step(z, 1'b0);

      // Asynchronous reset while a fetch read is in flight.
      load_mode = 0; f_req = 1; f_addr = 32'h4; l_req = 0; l_we = 0;
      #2;
      chk("pre_rst_f_gnt", 32'(f_gnt), 1);
      #1;
      reset = 1'b1;
      #1;
      chk("arst_f_gnt", 32'(f_gnt), 0);
      chk("arst_m_we", 32'(m_we), 0);
      chk("arst_f_rvalid", 32'(f_rvalid), 0);
      chk("arst_f_rdata", f_rdata, 0);
      f_req = 0;
      #1;
      reset = 1'b0;
      denied = 0; pend_kind = 0; pend_data = '0;
      @(posedge clk);
      #1;
      chk("post_rst_f_rvalid", 32'(f_rvalid), 0);

      // load_mode raised while a fetch read is outstanding keeps its rvalid.
      step(mk(0, 1, 32'h14, 0, 0, 0, 0, 1, 0, 5, 0), 1'b1);
      step(mk(1, 1, 32'h14, 0, 0, 0, 0, 0, 0, 5, 0), 1'b1);

      // Idle stretch.
      for (int i = 0; i < 10; i++) step(z, 1'b1);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         vec_t v;
         v = z;
         v.lm  = ($urandom_range(0, 7) == 0);
         v.fr  = ($urandom_range(0, 3) != 0);
         v.fa  = $urandom;
         v.lr  = ($urandom_range(0, 2) != 0);
         v.lwe = $urandom_range(0, 1);
         v.la  = $urandom;
         v.lwd = $urandom;
         step(v, 1'b0);
      end
      step(z, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
